// File: rtl/alu_sequencer_if.sv
// Bus bundle for alu_sequencer: instruction handshake, host register
// access, ALU drive/return and retire status.
interface alu_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [4:0]  alu_F;
    logic [15:0] alu_A;
    logic [15:0] alu_B;
    logic        alu_Cin;
    logic [15:0] alu_Result;
    logic [5:0]  alu_Status;
    logic [5:0]  flags;
    logic        done;
    logic        err;

    modport master (
        output instr_valid, instr,
        output ld_en, ld_addr, ld_data, rd_addr,
        output alu_Result, alu_Status,
        input  instr_ready, rd_data,
        input  alu_F, alu_A, alu_B, alu_Cin,
        input  flags, done, err
    );

    modport slave (
        input  instr_valid, instr,
        input  ld_en, ld_addr, ld_data, rd_addr,
        input  alu_Result, alu_Status,
        output instr_ready, rd_data,
        output alu_F, alu_A, alu_B, alu_Cin,
        output flags, done, err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Two-state execution controller feeding a 16-bit ALU from an 8x16
// register file, with writeback and a persistent status flag register.
module alu_sequencer (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    state_e      state_q;
    state_e      state_d;

    logic [15:0] rf_q [8];
    logic [5:0]  flags_q;
    logic [4:0]  alu_f_q;
    logic [15:0] alu_a_q;
    logic [15:0] alu_b_q;
    logic        alu_cin_q;
    logic [2:0]  rd_q;
    logic        legal_q;
    logic        done_q;
    logic        err_q;

    logic        ready;
    logic        accept;
    logic        wb_en;
    logic        done_d;
    logic        err_d;

    logic [4:0]  dec_f;
    logic [2:0]  dec_rd;
    logic [2:0]  dec_rs1;
    logic [2:0]  dec_rs2;
    logic        dec_legal;
    logic [1:0]  instr_unused;

    assign dec_f        = bus.instr[15:11];
    assign dec_rd       = bus.instr[10:8];
    assign dec_rs1      = bus.instr[7:5];
    assign dec_rs2      = bus.instr[4:2];
    assign instr_unused = bus.instr[1:0];

    assign dec_legal = dec_f inside {
        5'h01, [5'h03:5'h0B], [5'h10:5'h17]
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.instr_valid) state_d = EXEC;
            EXEC: state_d = IDLE;
        endcase
    end

    // Writeback and retire pulses come from the legality latched at accept.
    always_comb begin
        ready  = 1'b0;
        accept = 1'b0;
        wb_en  = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready  = 1'b1;
                accept = bus.instr_valid;
            end
            EXEC: begin
                wb_en  = legal_q;
                done_d = legal_q;
                err_d  = ~legal_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_f_q   <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_cin_q <= 1'b0;
            rd_q      <= '0;
            legal_q   <= 1'b0;
        end else if (accept) begin
            alu_f_q   <= dec_f;
            alu_a_q   <= rf_q[dec_rs1];
            alu_b_q   <= rf_q[dec_rs2];
            alu_cin_q <= flags_q[5];
            rd_q      <= dec_rd;
            legal_q   <= dec_legal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
            if (wb_en) flags_q <= bus.alu_Status;
        end
    end

    // Writeback is assigned last so it overrides a same-address host load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            if (bus.ld_en) rf_q[bus.ld_addr] <= bus.ld_data;
            if (wb_en)     rf_q[rd_q] <= bus.alu_Result;
        end
    end

    assign bus.instr_ready = ready;
    assign bus.rd_data     = rf_q[bus.rd_addr];
    assign bus.alu_F       = alu_f_q;
    assign bus.alu_A       = alu_a_q;
    assign bus.alu_B       = alu_b_q;
    assign bus.alu_Cin     = alu_cin_q;
    assign bus.flags       = flags_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus random bench for alu_sequencer with a behavioural ALU and
// a register-file/flags reference model.
module tb_alu_sequencer;
    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    logic [15:0] ref_r [8];
    logic [5:0]  ref_flags;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic is_legal(input logic [4:0] f);
        return f inside {5'h01, [5'h03:5'h0B], [5'h10:5'h17]};
    endfunction

    // Behavioural ALU: {C,Z,N,V,P,AC, result}
    function automatic logic [21:0] alu_fn(input logic [4:0] f,
                                           input logic [15:0] a,
                                           input logic [15:0] b,
                                           input logic cin);
        logic [16:0] w;
        logic [15:0] r;
        w = '0;
        case (f)
            5'h01: w = {1'b0, a} + 17'd1;
            5'h03: w = {1'b0, a} - 17'd1;
            5'h04: w = {1'b0, a} + {1'b0, b};
            5'h05: w = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            5'h06: w = {1'b0, a} - {1'b0, b};
            5'h07: w = {1'b0, a} - {1'b0, b} - {16'd0, cin};
            5'h08: w = {1'b0, a & b};
            5'h09: w = {1'b0, a | b};
            5'h0A: w = {1'b0, a ^ b};
            5'h0B: w = {1'b0, ~a};
            5'h10: w = {a, 1'b0};
            5'h11: w = {a[0], 1'b0, a[15:1]};
            5'h12: w = {a[0], a[15], a[15:1]};
            5'h13: w = {a[15], a[14:0], a[15]};
            5'h14: w = {a[0], a[0], a[15:1]};
            5'h15: w = {1'b0, a};
            5'h16: w = {a, cin};
            5'h17: w = {a[0], cin, a[15:1]};
            default: w = '0;
        endcase
        r = w[15:0];
        return {w[16], r == 16'd0, r[15], a[15] ^ r[15], ~^r,
                a[4] ^ b[4] ^ r[4], r};
    endfunction

    always_comb begin
        {bus.alu_Status, bus.alu_Result} =
            alu_fn(bus.alu_F, bus.alu_A, bus.alu_B, bus.alu_Cin);
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input int i, input string tag);
        bus.rd_addr = 3'(i);
        #1;
        chk(tag, bus.rd_data, ref_r[i]);
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 8; i++) ref_r[i] = '0;
        ref_flags = '0;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        @(posedge clk); #1;
        bus.ld_en = 1'b0;
        ref_r[a] = d;
    endtask

    task automatic issue(input logic [4:0] f, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic ld, input logic [2:0] la,
                         input logic [15:0] ldd);
        logic [21:0] o;
        int n;
        n = 0;
        while (bus.instr_ready !== 1'b1 && n < 4) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_pre", 16'(bus.instr_ready), 16'd1);
        bus.instr_valid = 1'b1;
        bus.instr = {f, rd, rs1, rs2, 2'($urandom)};
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.instr = 16'($urandom);
        chk("ready_exec", 16'(bus.instr_ready), 16'd0);
        chk("alu_F", 16'(bus.alu_F), 16'(f));
        chk("alu_A", bus.alu_A, ref_r[rs1]);
        chk("alu_B", bus.alu_B, ref_r[rs2]);
        chk("alu_Cin", 16'(bus.alu_Cin), 16'(ref_flags[5]));
        chk("done_exec", 16'(bus.done), 16'd0);
        chk("err_exec", 16'(bus.err), 16'd0);
        o = alu_fn(f, ref_r[rs1], ref_r[rs2], ref_flags[5]);
        if (ld) begin
            bus.ld_en   = 1'b1;
            bus.ld_addr = la;
            bus.ld_data = ldd;
        end
        @(posedge clk); #1;
        bus.ld_en = 1'b0;
        if (ld) ref_r[la] = ldd;
        if (is_legal(f)) begin
            ref_r[rd] = o[15:0];
            ref_flags = o[21:16];
        end
        chk("done", 16'(bus.done), 16'(is_legal(f)));
        chk("err", 16'(bus.err), 16'(!is_legal(f)));
        chk("ready_post", 16'(bus.instr_ready), 16'd1);
        chk("flags", 16'(bus.flags), 16'(ref_flags));
        chk_reg(int'(rd), "rd_wb");
        if (ld) chk_reg(int'(la), "ld_reg");
    endtask

    initial begin
        logic [4:0] rf;
        logic [21:0] o;
        compared   = 0;
        mismatched = 0;
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr   = '0;
        bus.ld_en   = 1'b0;
        bus.ld_addr = '0;
        bus.ld_data = '0;
        bus.rd_addr = '0;
        ref_reset();
        #5;
        chk("rst_ready", 16'(bus.instr_ready), 16'd1);
        chk("rst_flags", 16'(bus.flags), 16'd0);
        chk("rst_done", 16'(bus.done), 16'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD with carry out
        load(3'd1, 16'hFFFF);
        load(3'd2, 16'h0001);
        issue(5'h04, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
        chk_reg(3, "add_R3");
        chk("add_R3_const", bus.rd_data, 16'h0000);
        chk("add_C", 16'(bus.flags[5]), 16'd1);
        chk("add_Z", 16'(bus.flags[4]), 16'd1);

        // Carry chaining
        load(3'd4, 16'h0000);
        load(3'd5, 16'h0000);
        chk("adc_cin_pre", 16'(ref_flags[5]), 16'(bus.flags[5]));
        issue(5'h05, 3'd6, 3'd4, 3'd5, 1'b0, 3'd0, 16'h0);
        chk("adc_Cin", 16'(bus.alu_Cin), 16'd1);
        bus.rd_addr = 3'd6; #1;
        chk("adc_R6", bus.rd_data, 16'h0001);
        issue(5'h17, 3'd7, 3'd6, 3'd6, 1'b0, 3'd0, 16'h0);
        chk("rcr_Cin", 16'(bus.alu_Cin), 16'd0);
        bus.rd_addr = 3'd7; #1;
        chk("rcr_R7", bus.rd_data, 16'h0000);
        chk("rcr_C", 16'(bus.flags[5]), 16'd1);

        // Illegal opcode
        issue(5'h02, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 16'h0);
        bus.rd_addr = 3'd1; #1;
        chk("ill_R1", bus.rd_data, 16'hFFFF);
        @(posedge clk); #1;
        chk("ill_err_once", 16'(bus.err), 16'd0);

        // Load collision
        load(3'd0, 16'h00F0);
        issue(5'h0B, 3'd2, 3'd0, 3'd0, 1'b1, 3'd2, 16'h1234);
        bus.rd_addr = 3'd2; #1;
        chk("coll_R2", bus.rd_data, 16'hFF0F);
        issue(5'h0B, 3'd2, 3'd0, 3'd0, 1'b1, 3'd5, 16'h1234);
        bus.rd_addr = 3'd5; #1;
        chk("coll_R5", bus.rd_data, 16'h1234);
        bus.rd_addr = 3'd2; #1;
        chk("coll_R2b", bus.rd_data, 16'hFF0F);

        // Back-to-back INC R1 with valid held high
        load(3'd1, 16'h0007);
        bus.instr_valid = 1'b1;
        bus.instr = {5'h01, 3'd1, 3'd1, 3'd1, 2'b00};
        @(posedge clk); #1;
        chk("b2b_rdy0", 16'(bus.instr_ready), 16'd0);
        @(posedge clk); #1;
        chk("b2b_done1", 16'(bus.done), 16'd1);
        chk("b2b_rdy1", 16'(bus.instr_ready), 16'd1);
        bus.rd_addr = 3'd1; #1;
        chk("b2b_R1a", bus.rd_data, 16'h0008);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        chk("b2b_done_gap", 16'(bus.done), 16'd0);
        chk("b2b_A2", bus.alu_A, 16'h0008);
        @(posedge clk); #1;
        chk("b2b_done2", 16'(bus.done), 16'd1);
        chk("b2b_R1b", bus.rd_data, 16'h0009);
        o = alu_fn(5'h01, 16'h0008, 16'h0008, 1'b0);
        ref_r[1] = 16'h0009;
        ref_flags = o[21:16];
        chk("b2b_flags", 16'(bus.flags), 16'(ref_flags));

        // Third instruction aborted by reset during EXEC
        bus.instr_valid = 1'b1;
        bus.instr = {5'h01, 3'd1, 3'd1, 3'd1, 2'b00};
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        chk("abort_exec", 16'(bus.instr_ready), 16'd0);
        rst_n = 1'b0;
        ref_reset();
        #1;
        chk("ar_ready", 16'(bus.instr_ready), 16'd1);
        chk("ar_F", 16'(bus.alu_F), 16'd0);
        chk("ar_A", bus.alu_A, 16'd0);
        chk("ar_B", bus.alu_B, 16'd0);
        chk("ar_Cin", 16'(bus.alu_Cin), 16'd0);
        chk("ar_flags", 16'(bus.flags), 16'd0);
        chk("ar_done", 16'(bus.done), 16'd0);
        chk("ar_err", 16'(bus.err), 16'd0);
        for (int i = 0; i < 8; i++) chk_reg(i, "ar_reg");
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ar_no_done", 16'(bus.done), 16'd0);
        chk("ar_R1", bus.rd_data, 16'h0000);

        // Random instructions against the reference model
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0)
                load(3'($urandom), 16'($urandom));
            rf = ($urandom_range(0, 4) == 0) ? 5'($urandom)
                 : 5'($urandom_range(1, 11));
            if ($urandom_range(0, 2) == 0) rf = 5'($urandom_range(16, 23));
            issue(rf, 3'($urandom), 3'($urandom), 3'($urandom),
                  ($urandom_range(0, 3) == 0), 3'($urandom),
                  16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                chk("idle_done", 16'(bus.done | bus.err), 16'd0);
            end
        end
        for (int i = 0; i < 8; i++) chk_reg(i, "final_reg");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Execution controller placed directly upstream of the 16-bit ALU. It accepts one instruction at a time over a valid/ready handshake and reads two operands from an internal 8x16 register file. It drives the ALU function, operand and carry-in inputs, then writes the ALU result back to the register file and the ALU status into a persistent flag register. It is the only source of the ALU's `F`, `A`, `B` and `Cin` inputs, and the only consumer of `Result` and `Status`.

## Interface
- No parameters. Widths are fixed: 16-bit data, 5-bit function, 6-bit status, 8 registers.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: an instruction is presented on `instr`.
- `instr_ready` out 1: high when the block can accept an instruction (state IDLE).
- `instr` in 16: `[15:11]` F, `[10:8]` rd, `[7:5]` rs1, `[4:2]` rs2, `[1:0]` ignored.
- `ld_en` in 1: host register-load strobe.
- `ld_addr` in 3: host load address.
- `ld_data` in 16: host load data.
- `rd_addr` in 3: debug read address.
- `rd_data` out 16: combinational `R[rd_addr]`.
- `alu_F` out 5: registered; to the ALU `F` input.
- `alu_A` out 16: registered; to the ALU `A` input.
- `alu_B` out 16: registered; to the ALU `B` input.
- `alu_Cin` out 1: registered; to the ALU `Cin` input.
- `alu_Result` in 16: from the ALU `Result` output.
- `alu_Status` in 6: from the ALU `Status` output; bit order {C, Z, N, V, P, AC}, bit 5 = C.
- `flags` out 6: registered copy of the last legal `alu_Status`.
- `done` out 1: one-cycle pulse when a legal instruction retires.
- `err` out 1: one-cycle pulse when an illegal opcode is rejected.

## Operation
- **Legal F codes:** 01, 03, 04, 05, 06, 07, 08, 09, 0A, 0B, 10–17 (hex). All other codes are illegal.
- **States:** IDLE, EXEC.
  - `instr_ready` = (state == IDLE).
  - No other states exist.
- **IDLE, on `instr_valid & instr_ready`:**
  - Latch `alu_F` ← F, `alu_A` ← R[rs1], `alu_B` ← R[rs2], `alu_Cin` ← `flags[5]`.
  - Latch rd and the legality of F.
  - Go to EXEC.
- **IDLE, no transfer:** hold every output. `instr` is don't-care.
- **EXEC, legal F:** R[rd] ← `alu_Result`, `flags` ← `alu_Status`, `done` ← 1 next cycle. Go to IDLE.
- **EXEC, illegal F:** no register write, `flags` unchanged, `err` ← 1 next cycle. Go to IDLE.
- **Operand aliasing:** rs1, rs2 and rd may be equal. Operands are the values read at accept.
- **Host load:** `ld_en` writes R[`ld_addr`] ← `ld_data` at the clock edge, in any state.
  - If EXEC writeback targets the same address in the same cycle, the writeback wins.
- **Register file:** no hardwired-zero register; R0 is ordinary.
- **Reset (`rst_n` low, asynchronous):**
  - State → IDLE; all R[i] = 0; `flags` = 0.
  - `alu_F`, `alu_A`, `alu_B`, `alu_Cin` = 0; `done` = 0; `err` = 0.
  - `instr_ready` reads 1 while in reset.
- **Reset mid-EXEC:** the instruction is aborted. No writeback, no `done`.

## Timing
- Accept at rising edge N, with `instr_valid` and `instr_ready` both high.
- Cycle N→N+1: the ALU inputs are stable from registers and the ALU settles combinationally. `instr_ready` = 0.
- Edge N+1: writeback and flag update.
- Cycle N+1→N+2:
  - `done` (or `err`) = 1.
  - `instr_ready` = 1.
  - `flags` and `rd_data` show the new values.
- Throughput is one instruction per 2 cycles.
  - Back-to-back: the next accept happens at edge N+2.
  - An instruction accepted at N+2 reads the value written at N+1; no hazard logic is required.
- `done` and `err` are never high together, and each is high for exactly one cycle per instruction.
- `alu_*` outputs hold their last values after retire until the next accept.
- The `Cin` used by ADD_CARRY/SUB_BORROW/RCL/RCR is the carry flag as of the accept edge.

## Test plan
- **Reset values:** assert `rst_n` = 0 mid-run.
  - All `R[i]`, `flags`, `alu_*`, `done` and `err` read 0, asynchronously, before the next clock edge.
  - `instr_ready` = 1.
- **ADD with carry out:**
  - Load R1 = FFFF, R2 = 0001; issue F = 04, rd = 3, rs1 = 1, rs2 = 2.
  - `done` pulses 2 edges after accept; R3 = 0000.
  - `flags[5]` (C) = 1 and `flags[4]` (Z) = 1.
  - `instr_ready` is low for exactly one cycle.
- **Carry chaining:**
  - Continue from the previous state: load R4 = 0000, R5 = 0000; issue F = 05, rd = 6, rs1 = 4, rs2 = 5.
  - `alu_Cin` = 1 and R6 = 0001.
  - Then issue F = 17 (RCR) on R6, rd = 7: `alu_Cin` = 0 (flags from the ADC), R7 = 0000, C = 1.
- **Illegal opcode:**
  - Issue F = 02 with rd = 1.
  - `err` pulses once, `done` stays 0, R1 and `flags` are unchanged, and `instr_ready` returns high.
- **Load collision:**
  - During EXEC of F = 0B (NOT) with R0 = 00F0 and rd = 2, assert `ld_en`, `ld_addr` = 2, `ld_data` = 1234.
  - R2 = FF0F (writeback wins).
  - Repeat with `ld_addr` = 5: R5 = 1234 and R2 = FF0F.
- **Back-to-back and reset abort:**
  - Hold `instr_valid` high with two instructions: INC R1→R1, then INC R1→R1, starting from R1 = 0007.
  - R1 = 0009 after 4 cycles, with two `done` pulses.
  - Then issue a third instruction and pull `rst_n` low during EXEC: no `done` pulse, all registers 0.
